// File: rtl/fft_pkg.sv
// Shared FFT helpers: base-4 digit arithmetic and reorder-buffer bank mapping.
package fft_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_e;

    // Number of base-4 digits in n (n is a power of 4).
    function automatic int unsigned log4n(input int unsigned n);
        int unsigned d = 0;
        for (int unsigned i = 1; i < 16; i++) begin
            if ((32'd1 << (2 * i)) <= n) d = i;
        end
        return d;
    endfunction

    // Reverse the j low base-4 digits of x.
    function automatic int unsigned digrev(input int unsigned x, input int unsigned j);
        int unsigned r = 0;
        int unsigned v = x;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i < j) begin
                r = (r << 2) | (v & 32'd3);
                v = v >> 2;
            end
        end
        return r;
    endfunction

    // Bank holding a bin with top digit t and low digit d.
    function automatic int unsigned bank_of(input int unsigned t, input int unsigned d);
        return (t + d) & 32'd3;
    endfunction

    // Bank-local address {half, t, middle digits}; mid_digits may be zero.
    function automatic int unsigned addr_of(input int unsigned half, input int unsigned t,
                                            input int unsigned m, input int unsigned mid_digits);
        return (half << (2 * mid_digits + 2)) | (t << (2 * mid_digits)) | m;
    endfunction

endpackage

// File: rtl/reorder_bank_ram.sv
// Simple dual-port bank: one write port, one registered synchronous read port.
module reorder_bank_ram #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DW     = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DW-1:0]     rd_data
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [DW-1:0] mem [DEPTH];

    // Storage write; contents are never cleared.
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register holds its value when idle so downstream data stays stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_digit_reverse_reorder.sv
// Reorders base-4 digit-reversed 4-lane FFT output into natural bin order (ping-pong).
module fft_digit_reverse_reorder
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned Num_of_samples = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             input_en,
    input  logic [WIDTH-1:0] input_real_0,
    input  logic [WIDTH-1:0] input_real_1,
    input  logic [WIDTH-1:0] input_real_2,
    input  logic [WIDTH-1:0] input_real_3,
    input  logic [WIDTH-1:0] input_imag_0,
    input  logic [WIDTH-1:0] input_imag_1,
    input  logic [WIDTH-1:0] input_imag_2,
    input  logic [WIDTH-1:0] input_imag_3,
    output logic             output_en,
    output logic [WIDTH-1:0] output_real_0,
    output logic [WIDTH-1:0] output_real_1,
    output logic [WIDTH-1:0] output_real_2,
    output logic [WIDTH-1:0] output_real_3,
    output logic [WIDTH-1:0] output_imag_0,
    output logic [WIDTH-1:0] output_imag_1,
    output logic [WIDTH-1:0] output_imag_2,
    output logic [WIDTH-1:0] output_imag_3
);

    localparam int unsigned M        = log4n(Num_of_samples);
    localparam int unsigned MID      = M - 2;
    localparam int unsigned BEATS    = Num_of_samples / 4;
    localparam int unsigned CNT_W    = 2 * M - 2;
    localparam int unsigned ADDR_W   = CNT_W + 1;
    localparam int unsigned DW       = 2 * WIDTH;
    localparam int unsigned MID_MASK = (32'd1 << (2 * MID)) - 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    logic [DW-1:0]     in_lane     [LANES];
    logic [CNT_W-1:0]  wr_cnt_q;
    logic              wr_half_q;
    logic              frame_ready_c;
    logic [1:0]        wr_d_c;
    logic [ADDR_W-1:0] wr_addr_c   [LANES];
    logic [DW-1:0]     wr_data_c   [LANES];

    rd_state_e         state_q, state_n;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_n;
    logic              rd_half_q, rd_half_n;
    logic              pending_q, pending_n;
    logic              rd_en_c;
    logic [1:0]        rd_t_c;
    logic [ADDR_W-1:0] rd_addr_c;

    logic [DW-1:0]     bank_dout   [LANES];
    logic              rd_vld_q;
    logic [1:0]        rd_t_q;
    logic [DW-1:0]     out_lane_c  [LANES];

    assign in_lane[0] = {input_real_0, input_imag_0};
    assign in_lane[1] = {input_real_1, input_imag_1};
    assign in_lane[2] = {input_real_2, input_imag_2};
    assign in_lane[3] = {input_real_3, input_imag_3};

    assign frame_ready_c = input_en && (wr_cnt_q == CNT_LAST);

    // Write-side beat counter and ping-pong half select.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            wr_half_q <= 1'b0;
        end else if (input_en) begin
            if (wr_cnt_q == CNT_LAST) begin
                wr_cnt_q  <= '0;
                wr_half_q <= ~wr_half_q;
            end else begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
        end
    end

    // Write crossbar: lane l of beat b goes to bank (l+d) mod 4 at {half, l, middle digits}.
    always_comb begin
        int unsigned rev;
        int unsigned mid;
        logic [1:0]  lane;
        rev    = digrev(32'(wr_cnt_q), M - 1);
        mid    = (rev >> 2) & MID_MASK;
        wr_d_c = wr_cnt_q[CNT_W-1 -: 2];
        lane   = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            lane                = 2'(j) - wr_d_c;
            wr_addr_c[2'(j)]    = ADDR_W'(addr_of(32'(wr_half_q), 32'(lane), mid, MID));
            wr_data_c[2'(j)]    = in_lane[lane];
        end
    end

    // Read FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RD_IDLE;
            rd_cnt_q  <= '0;
            rd_half_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            rd_cnt_q  <= rd_cnt_n;
            rd_half_q <= rd_half_n;
            pending_q <= pending_n;
        end
    end

    // Read FSM next state: chain frames back to back, idle when nothing is waiting.
    always_comb begin
        state_n   = state_q;
        rd_cnt_n  = rd_cnt_q;
        rd_half_n = rd_half_q;
        pending_n = pending_q;
        case (state_q)
            RD_IDLE: begin
                if (frame_ready_c) begin
                    state_n   = RD_READ;
                    rd_cnt_n  = '0;
                    rd_half_n = wr_half_q;
                end
            end
            RD_READ: begin
                if (rd_cnt_q == CNT_LAST) begin
                    if (pending_q || frame_ready_c) begin
                        rd_cnt_n  = '0;
                        rd_half_n = ~rd_half_q;
                        pending_n = pending_q && frame_ready_c;
                    end else begin
                        state_n = RD_IDLE;
                    end
                end else begin
                    rd_cnt_n = rd_cnt_q + CNT_W'(1);
                    if (frame_ready_c) pending_n = 1'b1;
                end
            end
            default: state_n = RD_IDLE;
        endcase
    end

    // Read address is common to all banks: {half, top digit of beat, middle digits}.
    assign rd_en_c   = (state_q == RD_READ);
    assign rd_t_c    = rd_cnt_q[CNT_W-1 -: 2];
    assign rd_addr_c = ADDR_W'(addr_of(32'(rd_half_q), 32'(rd_t_c),
                                       32'(rd_cnt_q) & MID_MASK, MID));

    for (genvar g = 0; g < LANES; g++) begin : g_bank
        reorder_bank_ram #(
            .ADDR_W (ADDR_W),
            .DW     (DW)
        ) u_ram (
            .clock   (clock),
            .reset   (reset),
            .wr_en   (input_en),
            .wr_addr (wr_addr_c[g]),
            .wr_data (wr_data_c[g]),
            .rd_en   (rd_en_c),
            .rd_addr (rd_addr_c),
            .rd_data (bank_dout[g])
        );
    end

    // Read crossbar: output lane l takes bank (t+l) mod 4, t delayed to match the RAM read.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            out_lane_c[2'(l)] = bank_dout[2'(bank_of(32'(rd_t_q), l))];
        end
    end

    // Output stage: valid follows the read pipeline, data registers update every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_vld_q      <= 1'b0;
            rd_t_q        <= '0;
            output_en     <= 1'b0;
            output_real_0 <= '0;
            output_real_1 <= '0;
            output_real_2 <= '0;
            output_real_3 <= '0;
            output_imag_0 <= '0;
            output_imag_1 <= '0;
            output_imag_2 <= '0;
            output_imag_3 <= '0;
        end else begin
            rd_vld_q      <= rd_en_c;
            rd_t_q        <= rd_t_c;
            output_en     <= rd_vld_q;
            output_real_0 <= out_lane_c[0][DW-1 -: WIDTH];
            output_real_1 <= out_lane_c[1][DW-1 -: WIDTH];
            output_real_2 <= out_lane_c[2][DW-1 -: WIDTH];
            output_real_3 <= out_lane_c[3][DW-1 -: WIDTH];
            output_imag_0 <= out_lane_c[0][WIDTH-1:0];
            output_imag_1 <= out_lane_c[1][WIDTH-1:0];
            output_imag_2 <= out_lane_c[2][WIDTH-1:0];
            output_imag_3 <= out_lane_c[3][WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_fft_digit_reverse_reorder.sv
// Bench for fft_digit_reverse_reorder: N=16/64/256 instances against a bin-order reference model.
module tb_fft_digit_reverse_reorder;

    localparam int unsigned W    = 32;
    localparam int          NDUT = 3;

    typedef struct packed {
        logic [1:0]       sel;
        logic [31:0]      cyc;
        logic [3:0][63:0] lane;
    } beat_t;

    logic            clock = 1'b0;
    logic            reset;
    logic [NDUT-1:0] en;
    logic [W-1:0]    in_re [4];
    logic [W-1:0]    in_im [4];
    logic [NDUT-1:0] o_en;
    logic [W-1:0]    o_re  [NDUT][4];
    logic [W-1:0]    o_im  [NDUT][4];

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    int          last_e = 0;
    beat_t       obs   [$];
    logic [63:0] exp_q [$];
    beat_t       bt;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        fft_digit_reverse_reorder #(
            .WIDTH          (W),
            .Num_of_samples (g == 0 ? 16 : (g == 1 ? 64 : 256))
        ) u_dut (
            .clock         (clock),
            .reset         (reset),
            .input_en      (en[g]),
            .input_real_0  (in_re[0]),
            .input_real_1  (in_re[1]),
            .input_real_2  (in_re[2]),
            .input_real_3  (in_re[3]),
            .input_imag_0  (in_im[0]),
            .input_imag_1  (in_im[1]),
            .input_imag_2  (in_im[2]),
            .input_imag_3  (in_im[3]),
            .output_en     (o_en[g]),
            .output_real_0 (o_re[g][0]),
            .output_real_1 (o_re[g][1]),
            .output_real_2 (o_re[g][2]),
            .output_real_3 (o_re[g][3]),
            .output_imag_0 (o_im[g][0]),
            .output_imag_1 (o_im[g][1]),
            .output_imag_2 (o_im[g][2]),
            .output_imag_3 (o_im[g][3])
        );
    end

    // Collect every valid output beat of every instance, stamped with its cycle.
    always @(negedge clock) begin
        for (int g = 0; g < NDUT; g++) begin
            if (o_en[g]) begin
                bt.sel = 2'(g);
                bt.cyc = 32'(cyc);
                for (int l = 0; l < 4; l++) bt.lane[l] = {o_re[g][l], o_im[g][l]};
                obs.push_back(bt);
            end
        end
    end

    // Bin index carried by stream position x: its base-4 digits read backwards.
    function automatic int drev(int x, int digits);
        int r = 0;
        for (int i = 0; i < digits; i++) r += ((x / (4 ** i)) % 4) * (4 ** (digits - 1 - i));
        return r;
    endfunction

    function automatic int ndigits(int n);
        int d = 0;
        int v = 1;
        while (v < n) begin
            v = v * 4;
            d++;
        end
        return d;
    endfunction

    task automatic chk(string tag, logic [63:0] obs_v, logic [63:0] exp_v);
        checks++;
        assert (obs_v === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs_v, exp_v);
        end
    endtask

    task automatic chk_zero(logic [1:0] sel, string tag);
        logic [63:0] acc = '0;
        for (int l = 0; l < 4; l++) acc = acc | {o_re[sel][l], o_im[sel][l]};
        chk({tag, "_en"}, 64'(o_en[sel]), 64'd0);
        chk({tag, "_data"}, acc, 64'd0);
    endtask

    // Drive one frame from a negedge; the model files each sample under its bin.
    task automatic send_frame(logic [1:0] sel, int n, bit rnd, int offset, bit gaps, bit zchk);
        int          m = ndigits(n);
        logic [63:0] nat [256];
        for (int b = 0; b < n / 4; b++) begin
            if (zchk) chk_zero(sel, "t5_zero_pre");
            for (int l = 0; l < 4; l++) begin
                int          k = drev(4 * b + l, m);
                logic [31:0] re;
                logic [31:0] im;
                if (rnd) begin
                    re = $urandom;
                    im = $urandom;
                end else begin
                    re = 32'(k + offset);
                    im = 32'(100 + k + offset);
                end
                in_re[l] = re;
                in_im[l] = im;
                nat[k]   = {re, im};
            end
            en[sel] = 1'b1;
            @(negedge clock);
            last_e = cyc;
            if (gaps) begin
                en[sel] = 1'b0;
                for (int l = 0; l < 4; l++) begin
                    in_re[l] = $urandom;
                    in_im[l] = $urandom;
                end
                @(negedge clock);
            end
        end
        en[sel] = 1'b0;
        for (int k = 0; k < n; k++) exp_q.push_back(nat[k]);
    endtask

    // Wait (bounded) for nbeats, then check count, latency, continuity and data.
    task automatic wait_and_check(logic [1:0] sel, int nbeats, int frame_beats, string tag);
        int budget  = 0;
        int foreign = 0;
        int holes   = 0;
        int fidx    = nbeats - frame_beats;
        while (obs.size() < nbeats && budget < 400) begin
            @(negedge clock);
            budget++;
        end
        repeat (6) @(negedge clock);
        chk({tag, "_beats"}, 64'(obs.size()), 64'(nbeats));
        if (obs.size() > fidx) chk({tag, "_latency"}, 64'(obs[fidx].cyc), 64'(last_e + 2));
        for (int i = 0; i < obs.size(); i++) begin
            if (obs[i].sel != sel) foreign++;
            if (i > 0 && obs[i].cyc != obs[i-1].cyc + 1) holes++;
        end
        chk({tag, "_foreign"}, 64'(foreign), 64'd0);
        chk({tag, "_gaps"}, 64'(holes), 64'd0);
        for (int i = 0; i < obs.size() && i < nbeats; i++) begin
            for (int l = 0; l < 4; l++) begin
                if (4 * i + l < exp_q.size())
                    chk($sformatf("%s_b%0d_l%0d", tag, i, l), obs[i].lane[l], exp_q[4 * i + l]);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        #(400000);
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        en    = '0;
        for (int l = 0; l < 4; l++) begin
            in_re[l] = '0;
            in_im[l] = '0;
        end
        repeat (3) @(negedge clock);
        chk_zero(2'd0, "rst16");
        chk_zero(2'd1, "rst64");
        chk_zero(2'd2, "rst256");
        reset = 1'b0;
        @(negedge clock);
        chk_zero(2'd0, "post16");
        chk_zero(2'd1, "post64");
        chk_zero(2'd2, "post256");

        // Single N=16 frame of digit-reversed indices.
        send_frame(2'd0, 16, 1'b0, 0, 1'b0, 1'b0);
        wait_and_check(2'd0, 4, 4, "t1");

        // Three back-to-back frames: continuous output, no idle cycles.
        send_frame(2'd0, 16, 1'b0, 0, 1'b0, 1'b0);
        send_frame(2'd0, 16, 1'b0, 16, 1'b0, 1'b0);
        send_frame(2'd0, 16, 1'b0, 32, 1'b0, 1'b0);
        wait_and_check(2'd0, 12, 4, "t2");

        // input_en toggling with junk data in the gaps.
        send_frame(2'd0, 16, 1'b0, 0, 1'b1, 1'b0);
        wait_and_check(2'd0, 4, 4, "t3");

        // N=64 exercises the middle-digit addressing.
        send_frame(2'd1, 64, 1'b0, 0, 1'b0, 1'b0);
        wait_and_check(2'd1, 16, 16, "t4");

        // Partial frame killed by reset, then a fresh random frame.
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < 4; l++) begin
                in_re[l] = $urandom;
                in_im[l] = $urandom;
            end
            en[0] = 1'b1;
            @(negedge clock);
        end
        en[0] = 1'b0;
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk_zero(2'd0, "t5_rst");
        end
        reset = 1'b0;
        send_frame(2'd0, 16, 1'b1, 0, 1'b0, 1'b1);
        chk_zero(2'd0, "t5_e0");
        @(negedge clock);
        chk_zero(2'd0, "t5_e1");
        wait_and_check(2'd0, 4, 4, "t5");

        // N=256 random frame against the digit-reversal model.
        send_frame(2'd2, 256, 1'b1, 0, 1'b0, 1'b0);
        wait_and_check(2'd2, 64, 64, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
